// File: rtl/jt12_cpu_if.sv
// JT12 host-bus write front end: address/data latching, register-bank write
// strobe, prescaler select (0x2D-0x2F), busy timing and the status byte.
module jt12_cpu_if #(
  parameter int unsigned BUSY_CYCLES = 32,
  parameter int unsigned BUSY_W      = 6
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       cen,
  input  logic       cpu_cs_n,
  input  logic       cpu_wr_n,
  input  logic [1:0] cpu_addr,
  input  logic [7:0] cpu_din,
  input  logic       flag_a,
  input  logic       flag_b,
  output logic [7:0] cpu_dout,
  output logic [7:0] reg_addr,
  output logic       reg_part,
  output logic [7:0] reg_din,
  output logic       reg_wr,
  output logic       busy,
  output logic       set_n6,
  output logic       set_n3,
  output logic       set_n2
);

  typedef enum logic [2:0] {
    PRE_6 = 3'b100,
    PRE_3 = 3'b010,
    PRE_2 = 3'b001
  } presc_t;

  presc_t            presc;
  logic              wr_act;
  logic              wr_last;
  logic              wr_ev;
  logic              addr_ev;
  logic              data_ev;
  logic              is_presc;
  logic              data_ok;
  logic [BUSY_W-1:0] counter;
  logic [BUSY_W-1:0] counter_nx;

  assign wr_act  = ~cpu_cs_n & ~cpu_wr_n;
  assign wr_ev   = wr_act & ~wr_last;
  assign addr_ev = wr_ev & ~cpu_addr[0];
  assign data_ev = wr_ev &  cpu_addr[0];

  // Prescaler registers live here, not in the bank: they bypass busy entirely.
  assign is_presc = ~reg_part &&
                    (reg_addr == 8'h2D || reg_addr == 8'h2E || reg_addr == 8'h2F);
  assign data_ok  = data_ev & ~is_presc & ~busy;

  // A load in the same clk as cen takes priority over the decrement.
  always_comb begin
    counter_nx = counter;
    if (data_ok)
      counter_nx = BUSY_W'(BUSY_CYCLES);
    else if (cen && counter != '0)
      counter_nx = counter - BUSY_W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_last  <= 1'b0;
      reg_addr <= '0;
      reg_part <= 1'b0;
      reg_din  <= '0;
      reg_wr   <= 1'b0;
      counter  <= '0;
      busy     <= 1'b0;
      cpu_dout <= '0;
      presc    <= PRE_6;
    end else begin
      wr_last  <= wr_act;
      reg_wr   <= data_ok;
      counter  <= counter_nx;
      busy     <= (counter_nx != '0);
      cpu_dout <= {busy, 5'b0, flag_b, flag_a};
      if (addr_ev) begin
        reg_addr <= cpu_din;
        reg_part <= cpu_addr[1];
      end
      if (data_ok)
        reg_din <= cpu_din;
      if (data_ev && is_presc) begin
        case (reg_addr[1:0])
          2'b01:   presc <= PRE_6;
          2'b10:   presc <= PRE_3;
          2'b11:   presc <= PRE_2;
          default: presc <= presc;
        endcase
      end
    end
  end

  assign set_n6 = presc[2];
  assign set_n3 = presc[1];
  assign set_n2 = presc[0];

endmodule

// File: tb/tb_jt12_cpu_if.sv
// Directed bench for jt12_cpu_if: bus writes, prescaler select, busy timing,
// status byte and reset behaviour.
module tb_jt12_cpu_if;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       cen;
  logic       cpu_cs_n;
  logic       cpu_wr_n;
  logic [1:0] cpu_addr;
  logic [7:0] cpu_din;
  logic       flag_a;
  logic       flag_b;
  logic [7:0] cpu_dout;
  logic [7:0] reg_addr;
  logic       reg_part;
  logic [7:0] reg_din;
  logic       reg_wr;
  logic       busy;
  logic       set_n6;
  logic       set_n3;
  logic       set_n2;

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;
  int cen_cnt  = 0;
  bit cen_on   = 1'b0;

  jt12_cpu_if #(.BUSY_CYCLES(32), .BUSY_W(6)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .cen      (cen),
    .cpu_cs_n (cpu_cs_n),
    .cpu_wr_n (cpu_wr_n),
    .cpu_addr (cpu_addr),
    .cpu_din  (cpu_din),
    .flag_a   (flag_a),
    .flag_b   (flag_b),
    .cpu_dout (cpu_dout),
    .reg_addr (reg_addr),
    .reg_part (reg_part),
    .reg_din  (reg_din),
    .reg_wr   (reg_wr),
    .busy     (busy),
    .set_n6   (set_n6),
    .set_n3   (set_n3),
    .set_n2   (set_n2)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  // cen pulses once every 6 clks while enabled; outputs sampled 1ns after the edge
  task automatic tick();
    cen = cen_on && (cyc % 6 == 5);
    @(posedge clk);
    #1;
    cyc++;
    if (cen) cen_cnt++;
  endtask

  task automatic bus_wr(input logic [1:0] a, input logic [7:0] d, input int hold,
                        output int pulses, output int ev_cen);
    cpu_cs_n = 1'b0;
    cpu_wr_n = 1'b0;
    cpu_addr = a;
    cpu_din  = d;
    pulses   = 0;
    ev_cen   = 0;
    for (int i = 0; i < hold; i++) begin
      tick();
      if (i == 0) begin
        ev_cen  = cen_cnt;
        cpu_din = ~d;
      end
      pulses += int'(reg_wr);
    end
    cpu_cs_n = 1'b1;
    cpu_wr_n = 1'b1;
    tick();
    pulses += int'(reg_wr);
  endtask

  task automatic wait_cen(input int target);
    int n = 0;
    while (cen_cnt < target && n < 2000) begin
      tick();
      n++;
    end
    check("cen_wait", 32'(cen_cnt == target), 32'd1);
  endtask

  initial begin
    int p;
    int ev;
    int ev2;
    rst_n    = 1'b0;
    cen      = 1'b0;
    cpu_cs_n = 1'b1;
    cpu_wr_n = 1'b1;
    cpu_addr = 2'b00;
    cpu_din  = 8'h00;
    flag_a   = 1'b0;
    flag_b   = 1'b0;
    repeat (3) tick();
    check("rst_reg_addr", reg_addr, 8'h00);
    check("rst_reg_part", reg_part, 1'b0);
    check("rst_reg_din",  reg_din,  8'h00);
    check("rst_reg_wr",   reg_wr,   1'b0);
    check("rst_busy",     busy,     1'b0);
    check("rst_dout",     cpu_dout, 8'h00);
    check("rst_presc",    {set_n6, set_n3, set_n2}, 3'b100);
    rst_n  = 1'b1;
    cen_on = 1'b1;
    flag_a = 1'b1;
    tick();

    // address 0x28 then data 0xF0
    bus_wr(2'b00, 8'h28, 1, p, ev);
    check("addr28_reg_addr", reg_addr, 8'h28);
    check("addr28_reg_part", reg_part, 1'b0);
    check("addr28_no_wr",    p, 0);
    check("addr28_busy",     busy, 1'b0);
    bus_wr(2'b01, 8'hF0, 1, p, ev);
    check("dataF0_pulses", p, 1);
    check("dataF0_reg_din", reg_din, 8'hF0);
    check("dataF0_busy", busy, 1'b1);
    repeat (8) tick();
    // dropped write while busy
    bus_wr(2'b01, 8'h11, 1, p, ev2);
    check("drop_pulses", p, 0);
    check("drop_reg_din", reg_din, 8'hF0);
    // prescaler write during busy still applies
    bus_wr(2'b00, 8'h2F, 1, p, ev2);
    bus_wr(2'b01, 8'h00, 1, p, ev2);
    check("busy_presc_2F", {set_n6, set_n3, set_n2}, 3'b001);
    bus_wr(2'b00, 8'h2D, 1, p, ev2);
    bus_wr(2'b01, 8'h00, 1, p, ev2);
    check("busy_presc_2D", {set_n6, set_n3, set_n2}, 3'b100);
    check("busy_presc_no_wr", p, 0);
    wait_cen(ev + 31);
    check("first_busy_31", busy, 1'b1);
    check("first_dout_31", cpu_dout, 8'h81);
    wait_cen(ev + 32);
    check("first_busy_32", busy, 1'b0);
    check("first_dout_lag", cpu_dout, 8'h81);
    tick();
    check("first_dout_after", cpu_dout, 8'h01);

    // prescaler select with busy idle
    bus_wr(2'b00, 8'h2F, 1, p, ev);
    bus_wr(2'b01, 8'h00, 1, p, ev);
    check("presc_2F", {set_n6, set_n3, set_n2}, 3'b001);
    check("presc_2F_no_wr", p, 0);
    check("presc_2F_busy", busy, 1'b0);
    bus_wr(2'b00, 8'h2E, 1, p, ev);
    bus_wr(2'b01, 8'h00, 1, p, ev);
    check("presc_2E", {set_n6, set_n3, set_n2}, 3'b010);
    bus_wr(2'b00, 8'h2D, 1, p, ev);
    bus_wr(2'b01, 8'h00, 1, p, ev);
    check("presc_2D", {set_n6, set_n3, set_n2}, 3'b100);

    // part 1 address 0x2F is an ordinary register
    flag_a = 1'b0;
    flag_b = 1'b1;
    bus_wr(2'b10, 8'h2F, 1, p, ev);
    check("p1_reg_part", reg_part, 1'b1);
    check("p1_reg_addr", reg_addr, 8'h2F);
    bus_wr(2'b11, 8'h55, 1, p, ev);
    check("p1_pulses", p, 1);
    check("p1_reg_din", reg_din, 8'h55);
    check("p1_presc", {set_n6, set_n3, set_n2}, 3'b100);
    check("p1_busy", busy, 1'b1);
    wait_cen(ev + 32);
    tick();
    check("p1_dout_after", cpu_dout, 8'h02);

    // long strobe: one event only, data sampled at the event
    bus_wr(2'b00, 8'h30, 1, p, ev);
    bus_wr(2'b01, 8'hA5, 20, p, ev);
    check("hold_pulses", p, 1);
    check("hold_reg_din", reg_din, 8'hA5);
    wait_cen(ev + 32);

    // event coinciding with cen loads the full count
    while (cyc % 6 != 5) tick();
    bus_wr(2'b01, 8'h3C, 1, p, ev);
    check("coin_pulses", p, 1);
    wait_cen(ev + 31);
    check("coin_busy_31", busy, 1'b1);
    wait_cen(ev + 32);
    check("coin_busy_32", busy, 1'b0);

    // reset mid-busy, then a strobe held across reset release
    bus_wr(2'b01, 8'h66, 1, p, ev);
    bus_wr(2'b00, 8'h2F, 1, p, ev2);
    bus_wr(2'b01, 8'h00, 1, p, ev2);
    check("pre_rst_busy", busy, 1'b1);
    check("pre_rst_presc", {set_n6, set_n3, set_n2}, 3'b001);
    rst_n = 1'b0;
    #1;
    check("rst_mid_busy", busy, 1'b0);
    check("rst_mid_presc", {set_n6, set_n3, set_n2}, 3'b100);
    cpu_cs_n = 1'b0;
    cpu_wr_n = 1'b0;
    cpu_addr = 2'b01;
    cpu_din  = 8'h77;
    repeat (2) tick();
    check("rst_hold_no_wr", reg_wr, 1'b0);
    rst_n = 1'b1;
    tick();
    check("rst_rel_wr", reg_wr, 1'b1);
    check("rst_rel_din", reg_din, 8'h77);
    tick();
    check("rst_rel_single", reg_wr, 1'b0);
    cpu_cs_n = 1'b1;
    cpu_wr_n = 1'b1;
    tick();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
